rv32e_mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the CPU instruction-fetch port and data port.
- Sits between rv32e_cpu and the memory model or SRAM wrapper.
- Arbitrates fixed-priority (data over instruction) and sequences a req/ready memory handshake with wait states.
- Bounds every access with a timeout and routes read data and a one-cycle ready pulse back to the owning requester.

---
 rtl/rv32e_mem_arbiter_if.sv | 46 ++++
 rtl/rv32e_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_rv32e_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32e_mem_arbiter_if.sv
// rtl/rv32e_mem_arbiter_if.sv - request/memory bus bundle shared by rv32e_mem_arbiter and its neighbours
//
// Purpose: carries the instruction-fetch port, the data port, the single-port
// memory handshake and the arbiter status flags as one bundle.
// Modports:
//   slave  - arbiter view: consumes i_*/d_* requests and memory responses,
//            drives ready/rdata back to the requesters, m_* to memory, err, busy.
//   master - environment view (CPU + memory): the mirror image of slave.
interface rv32e_mem_arbiter_if;
  // instruction fetch port
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  // data port
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  // memory side
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;
  // status
  logic        err;
  logic        busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata, m_ready,
    output i_rdata, i_ready, d_rdata, d_ready,
    output m_req, m_we, m_be, m_addr, m_wdata, err, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata, m_ready,
    input  i_rdata, i_ready, d_rdata, d_ready,
    input  m_req, m_we, m_be, m_addr, m_wdata, err, busy
  );
endinterface

// File: rtl/rv32e_mem_arbiter.sv
// rtl/rv32e_mem_arbiter.sv - fixed-priority arbiter sharing one single-port memory between fetch and data ports
//
// Purpose: grants the memory to the data port first, otherwise to the fetch
// port, latches the owner's request into registered m_* outputs, waits for
// m_ready (bounded by MAX_WAIT) and returns a one-cycle ready pulse plus read
// data to the owner only. Every access is followed by an IDLE cycle.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   bus   - rv32e_mem_arbiter_if.slave (i_*, d_*, m_*, err, busy)
// Parameters:
//   MAX_WAIT     - wait cycles tolerated before an access is aborted with err (1..65535)
//   STARVE_LIMIT - consecutive data grants allowed while a fetch waits
// Optional feature macro: ARB_STARVE_GUARD_EN (starvation guard for the fetch port).
module rv32e_mem_arbiter #(
  parameter int unsigned MAX_WAIT     = 255,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  rv32e_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  localparam logic [15:0] WAIT_LIMIT = 16'(MAX_WAIT);

  state_t      state;
  logic [15:0] wait_cnt;
  logic        serving;
  logic        timeout;
  logic        done;
  logic        grant_d;
  logic        grant_i;

  // Responses are suppressed while reset is asserted so a reset that lands
  // mid-access never produces a ready or err pulse.
  assign serving = (state != IDLE) && !reset;
  assign timeout = serving && !bus.m_ready && (wait_cnt == WAIT_LIMIT);
  assign done    = serving && (bus.m_ready || timeout);

  assign bus.i_ready = done && (state == SERVE_I);
  assign bus.d_ready = done && (state == SERVE_D);
  assign bus.err     = timeout;
  assign bus.busy    = (state != IDLE);

  // Read data is forwarded only on a genuine completion; timeouts return 0.
  assign bus.i_rdata = (serving && bus.m_ready && state == SERVE_I) ? bus.m_rdata : 32'h0;
  assign bus.d_rdata = (serving && bus.m_ready && state == SERVE_D) ? bus.m_rdata : 32'h0;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          starve_hit;

  // Once the data port has won STARVE_LIMIT times in a row over a waiting
  // fetch, the next contended grant goes to the fetch port.
  assign starve_hit = bus.i_req && (starve_cnt == SW'(STARVE_LIMIT));
  assign grant_d    = bus.d_req && !starve_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_d) begin
        starve_cnt <= bus.i_req ? starve_cnt + 1'b1 : '0;
      end else if (grant_i) begin
        starve_cnt <= '0;
      end
    end
  end
`else
  assign grant_d = bus.d_req;
`endif

  assign grant_i = bus.i_req && !grant_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= 16'h0;
      bus.m_req   <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_be    <= 4'h0;
      bus.m_addr  <= 32'h0;
      bus.m_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= 16'h0;
          if (grant_d) begin
            state       <= SERVE_D;
            bus.m_req   <= 1'b1;
            bus.m_we    <= bus.d_we;
            bus.m_be    <= bus.d_be;
            bus.m_addr  <= bus.d_addr;
            bus.m_wdata <= bus.d_wdata;
          end else if (grant_i) begin
            state       <= SERVE_I;
            bus.m_req   <= 1'b1;
            bus.m_we    <= 1'b0;
            bus.m_be    <= 4'b1111;
            bus.m_addr  <= bus.i_addr;
            bus.m_wdata <= 32'h0;
          end
        end
        SERVE_I, SERVE_D: begin
          // Always fall back to IDLE so a requester that drops req after
          // ready is never granted a second time.
          if (done) begin
            state     <= IDLE;
            bus.m_req <= 1'b0;
            bus.m_we  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: begin
          state     <= IDLE;
          bus.m_req <= 1'b0;
          bus.m_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32e_mem_arbiter.sv
// tb/tb_rv32e_mem_arbiter.sv - self-checking bench for rv32e_mem_arbiter
module tb_rv32e_mem_arbiter;

  localparam int MAX_WAIT_TB = 8;
  localparam int STARVE_TB   = 4;

  logic clk = 1'b0;
  logic reset;

  rv32e_mem_arbiter_if bus ();

  rv32e_mem_arbiter #(.MAX_WAIT(MAX_WAIT_TB), .STARVE_LIMIT(STARVE_TB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // memory responder state
  int cur_wait = 0;
  bit hang     = 1'b0;
  int req_age  = 0;

  logic [31:0] tb_mem  [logic [31:0]];   // contents as seen through the m_* port
  logic [31:0] ref_mem [logic [31:0]];   // contents implied by the requests issued

  function automatic logic [31:0] tb_rd(input logic [31:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: memory answers after cur_wait cycles of m_req, then outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!bus.m_req) req_age = 0;
    bus.m_ready = bus.m_req && !hang && (req_age == cur_wait);
    bus.m_rdata = bus.m_ready ? tb_rd(bus.m_addr) : 32'hA5A5_A5A5;
    if (bus.m_ready && bus.m_we) tb_mem[bus.m_addr] = merge(tb_rd(bus.m_addr), bus.m_wdata, bus.m_be);
    if (bus.m_req) req_age++;
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_req = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_be = 0; bus.d_addr = 0; bus.d_wdata = 0;
  endtask

  // Single uncontended access: ready expected exactly waits+1 cycles after the request.
  task automatic do_access(input bit is_d, input bit we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata, input int waits);
    logic [31:0] exp_rd;
    logic        rdy, other;
    cur_wait = waits;
    hang     = 1'b0;
    exp_rd   = ref_rd(addr);
    if (is_d) begin
      bus.d_req = 1; bus.d_we = we; bus.d_be = be; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.i_req = 1; bus.i_addr = addr;
    end
    for (int t = 1; t <= waits + 1; t++) begin
      tick();
      rdy   = is_d ? bus.d_ready : bus.i_ready;
      other = is_d ? bus.i_ready : bus.d_ready;
      if (t == 1) begin
        chk("acc_m_req",   32'(bus.m_req), 32'd1);
        chk("acc_m_addr",  bus.m_addr, addr);
        chk("acc_m_we",    32'(bus.m_we), is_d ? 32'(we) : 32'd0);
        chk("acc_m_be",    32'(bus.m_be), is_d ? 32'(be) : 32'hF);
        chk("acc_m_wdata", bus.m_wdata, is_d ? wdata : 32'h0);
      end
      chk("acc_other_ready", 32'(other), 32'd0);
      if (t <= waits) begin
        chk("acc_early_ready", 32'(rdy), 32'd0);
      end else begin
        chk("acc_ready", 32'(rdy), 32'd1);
        chk("acc_err",   32'(bus.err), 32'd0);
        chk("acc_rdata", is_d ? bus.d_rdata : bus.i_rdata, exp_rd);
      end
    end
    clear_inputs();
    if (is_d && we) ref_mem[addr] = merge(exp_rd, wdata, be);
    tick();
    chk("acc_idle_busy",  32'(bus.busy), 32'd0);
    chk("acc_idle_m_req", 32'(bus.m_req), 32'd0);
    chk("acc_idle_ready", 32'({bus.i_ready, bus.d_ready}), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] wd;
    logic [3:0]  be;
    bit          is_d, we;
    int          n_done, n_igr;
    bit          exp_i;

    clear_inputs();
    bus.m_ready = 0; bus.m_rdata = 0;
    for (int a = 0; a < 16; a++) begin
      v = $urandom;
      tb_mem[32'(a * 4)]  = v;
      ref_mem[32'(a * 4)] = v;
    end
    tb_mem[32'h100]  = 32'h0050_0093;  ref_mem[32'h100]  = 32'h0050_0093;
    tb_mem[32'h2004] = 32'h1122_3344;  ref_mem[32'h2004] = 32'h1122_3344;

    // reset state
    reset = 1;
    tick(); tick();
    chk("rst_m_req",   32'(bus.m_req), 32'd0);
    chk("rst_m_we",    32'(bus.m_we), 32'd0);
    chk("rst_m_be",    32'(bus.m_be), 32'd0);
    chk("rst_m_addr",  bus.m_addr, 32'h0);
    chk("rst_m_wdata", bus.m_wdata, 32'h0);
    chk("rst_ready",   32'({bus.i_ready, bus.d_ready, bus.err}), 32'd0);
    chk("rst_busy",    32'(bus.busy), 32'd0);
    reset = 0;
    tick();

    // zero-wait fetch
    do_access(1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 0);

    // contention: store wins, IDLE gap, then fetch of the same word
    cur_wait = 2;
    bus.i_req = 1; bus.i_addr = 32'h2004;
    bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0011; bus.d_addr = 32'h2004; bus.d_wdata = 32'hDEAD_BEEF;
    for (int t = 1; t <= 3; t++) begin
      tick();
      if (t == 1) begin
        chk("cont_m_we",    32'(bus.m_we), 32'd1);
        chk("cont_m_be",    32'(bus.m_be), 32'b0011);
        chk("cont_m_addr",  bus.m_addr, 32'h2004);
        chk("cont_m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
      end
      chk("cont_i_ready", 32'(bus.i_ready), 32'd0);
      chk("cont_d_ready", 32'(bus.d_ready), (t == 3) ? 32'd1 : 32'd0);
    end
    bus.d_req = 0;
    ref_mem[32'h2004] = merge(32'h1122_3344, 32'hDEAD_BEEF, 4'b0011);
    tick();
    chk("cont_gap_busy", 32'(bus.busy), 32'd0);
    for (int t = 1; t <= 3; t++) begin
      tick();
      if (t == 1) begin
        chk("cont_f_addr", bus.m_addr, 32'h2004);
        chk("cont_f_we",   32'(bus.m_we), 32'd0);
      end
      chk("cont_f_ready", 32'(bus.i_ready), (t == 3) ? 32'd1 : 32'd0);
    end
    chk("cont_f_rdata", bus.i_rdata, 32'h1122_BEEF);
    clear_inputs();
    tick();

    // timeout: load with memory never answering
    hang = 1; cur_wait = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h30;
    for (int t = 1; t <= MAX_WAIT_TB + 1; t++) begin
      tick();
      if (t <= MAX_WAIT_TB) begin
        chk("to_early_ready", 32'({bus.d_ready, bus.err}), 32'd0);
        chk("to_m_req",       32'(bus.m_req), 32'd1);
      end else begin
        chk("to_d_ready", 32'(bus.d_ready), 32'd1);
        chk("to_err",     32'(bus.err), 32'd1);
        chk("to_d_rdata", bus.d_rdata, 32'h0);
      end
    end
    clear_inputs();
    hang = 0;
    tick();
    chk("to_idle_busy", 32'(bus.busy), 32'd0);
    chk("to_idle_err",  32'(bus.err), 32'd0);

    // reset on the second wait cycle of a data access
    hang = 1;
    bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h8;
    tick(); tick();
    reset = 1;
    #1;
    chk("rm_no_pulse", 32'({bus.d_ready, bus.err}), 32'd0);
    tick();
    chk("rm_m_req", 32'(bus.m_req), 32'd0);
    chk("rm_busy",  32'(bus.busy), 32'd0);
    chk("rm_pulse", 32'({bus.d_ready, bus.err}), 32'd0);
    reset = 0; hang = 0;
    clear_inputs();
    tick();
    do_access(1'b1, 1'b0, 4'hF, 32'h8, 32'h0, 0);

    // latched request: d_addr/d_wdata wiggle during a 3-wait store
    cur_wait = 3;
    bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'hF; bus.d_addr = 32'h3C; bus.d_wdata = 32'h1234_5678;
    for (int t = 1; t <= 4; t++) begin
      tick();
      chk("stab_m_addr",  bus.m_addr, 32'h3C);
      chk("stab_m_wdata", bus.m_wdata, 32'h1234_5678);
      chk("stab_d_ready", 32'(bus.d_ready), (t == 4) ? 32'd1 : 32'd0);
      bus.d_addr  = $urandom;
      bus.d_wdata = $urandom;
    end
    clear_inputs();
    ref_mem[32'h3C] = 32'h1234_5678;
    tick();

    // randomized single accesses against the reference memory
    for (int k = 0; k < 30; k++) begin
      is_d = 1'($urandom_range(0, 1));
      we   = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      be   = 4'($urandom_range(1, 15));
      wd   = $urandom;
      do_access(is_d, we, be, 32'($urandom_range(0, 15) * 4), wd, $urandom_range(0, 3));
    end
    for (int a = 0; a < 16; a++) chk("mem_image", tb_rd(32'(a * 4)), ref_rd(32'(a * 4)));

    // starvation: both ports request continuously for 20 accesses
    reset = 1;
    tick();
    reset = 0;
    cur_wait = 0;
    bus.i_req = 1; bus.i_addr = 32'h400;
    bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h800;
    n_done = 0; n_igr = 0;
    for (int t = 0; t < 100 && n_done < 20; t++) begin
      tick();
      if (bus.i_ready || bus.d_ready) begin
`ifdef ARB_STARVE_GUARD_EN
        exp_i = ((n_done % (STARVE_TB + 1)) == STARVE_TB);
`else
        exp_i = 1'b0;
`endif
        chk("starve_owner", 32'(bus.i_ready), 32'(exp_i));
        if (bus.i_ready) n_igr++;
        n_done++;
      end
    end
    chk("starve_done", 32'(n_done), 32'd20);
`ifdef ARB_STARVE_GUARD_EN
    chk("starve_i_grants", 32'(n_igr), 32'(20 / (STARVE_TB + 1)));
`else
    chk("starve_i_grants", 32'(n_igr), 32'd0);
`endif
    clear_inputs();
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
